// File: rtl/reg_bank.sv
// Multi-port register bank: one write port, two combinational read ports with
// optional write-to-read forwarding, and a sequential bulk-clear engine.
module reg_bank #(
  parameter int N      = 16,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset_N,
  input  logic          Load,
  input  logic [AW-1:0] Wr_Addr,
  input  logic [N-1:0]  Data_In,
  input  logic [AW-1:0] Rd_Addr_A,
  input  logic [AW-1:0] Rd_Addr_B,
  output logic [N-1:0]  Data_Out_A,
  output logic [N-1:0]  Data_Out_B,
  input  logic          Clear,
  output logic          Busy,
  output logic          Clear_Done
);

  typedef enum logic {IDLE, CLEARING} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic          wr_en;

  // Writes are refused during a clear and for indices past the last entry.
  assign wr_en      = Load && (state_q == IDLE) && (int'(Wr_Addr) < DEPTH);
  assign Busy       = (state_q == CLEARING);
  assign Clear_Done = done_q;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    if (wr_en) mem_d[Wr_Addr] = Data_In;
    case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        mem_d[cnt_q] = '0;
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
    endcase
  end

  // NOTE: the storage array is reset too, because every entry must read zero
  // straight out of reset; this forces flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  // Forwarding keys off wr_en, so nothing is forwarded while clearing.
  always_comb begin
    Data_Out_A = '0;
    if (int'(Rd_Addr_A) < DEPTH) begin
      if ((BYPASS != 0) && wr_en && (Rd_Addr_A == Wr_Addr)) Data_Out_A = Data_In;
      else                                                  Data_Out_A = mem_q[Rd_Addr_A];
    end
  end

  always_comb begin
    Data_Out_B = '0;
    if (int'(Rd_Addr_B) < DEPTH) begin
      if ((BYPASS != 0) && wr_en && (Rd_Addr_B == Wr_Addr)) Data_Out_B = Data_In;
      else                                                  Data_Out_B = mem_q[Rd_Addr_B];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: vector table for read/write/forwarding plus
// hand sequences for bulk clear, collisions, reset abort and a 6-entry bank.
module tb_reg_bank;

  localparam int N  = 16;
  localparam int AW = 3;

  logic          Clk;
  logic          Reset_N, Load, Clear;
  logic [AW-1:0] Wr_Addr, Rd_Addr_A, Rd_Addr_B;
  logic [N-1:0]  Data_In;
  logic [N-1:0]  out_a, out_b, nb_a, nb_b;
  logic          busy, done, nb_busy, nb_done;

  logic          l6, clr6;
  logic [AW-1:0] wa6, ra6, rb6;
  logic [N-1:0]  d6, a6, b6;
  logic          busy6, done6;

  int total = 0;
  int bad   = 0;

  reg_bank #(.N(N), .DEPTH(8), .BYPASS(1)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Load(Load), .Wr_Addr(Wr_Addr), .Data_In(Data_In),
    .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B), .Data_Out_A(out_a), .Data_Out_B(out_b),
    .Clear(Clear), .Busy(busy), .Clear_Done(done)
  );

  reg_bank #(.N(N), .DEPTH(8), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset_N(Reset_N), .Load(Load), .Wr_Addr(Wr_Addr), .Data_In(Data_In),
    .Rd_Addr_A(Rd_Addr_A), .Rd_Addr_B(Rd_Addr_B), .Data_Out_A(nb_a), .Data_Out_B(nb_b),
    .Clear(Clear), .Busy(nb_busy), .Clear_Done(nb_done)
  );

  reg_bank #(.N(N), .DEPTH(6), .BYPASS(1)) dut6 (
    .Clk(Clk), .Reset_N(Reset_N), .Load(l6), .Wr_Addr(wa6), .Data_In(d6),
    .Rd_Addr_A(ra6), .Rd_Addr_B(rb6), .Data_Out_A(a6), .Data_Out_B(b6),
    .Clear(clr6), .Busy(busy6), .Clear_Done(done6)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic          load;
    logic [AW-1:0] wr;
    logic [N-1:0]  din;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [N-1:0]  ea;
    logic [N-1:0]  eb;
    logic [N-1:0]  ena;
  } vec_t;

  vec_t vecs [9];
  int   pulses;

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'h1234, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd3, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1'b1, 3'd7, 16'h0077, 3'd7, 3'd0, 16'h0077, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 3'd0, 16'h0A0A, 3'd7, 3'd0, 16'h0077, 16'h0A0A, 16'h0077};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0A0A, 16'h0077, 16'h0A0A};
    vecs[7] = '{1'b1, 3'd3, 16'h5555, 3'd3, 3'd3, 16'h5555, 16'h5555, 16'h1234};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'h5555, 16'hBEEF, 16'h5555};

    Reset_N = 1'b0; Load = 1'b0; Clear = 1'b0; Wr_Addr = '0; Data_In = '0;
    Rd_Addr_A = 3'd0; Rd_Addr_B = 3'd7;
    l6 = 1'b0; clr6 = 1'b0; wa6 = '0; d6 = '0; ra6 = '0; rb6 = '0;

    // Reset state
    #8;
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset done", done, 1'b0);
    check("reset read a", out_a, 16'h0000);
    check("reset read b", out_b, 16'h0000);
    #4 Reset_N = 1'b1;
    tick();

    // Read/write/forwarding table
    for (int i = 0; i < 9; i++) begin
      Load = vecs[i].load; Wr_Addr = vecs[i].wr; Data_In = vecs[i].din;
      Rd_Addr_A = vecs[i].ra; Rd_Addr_B = vecs[i].rb;
      #1;
      check($sformatf("vec%0d a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d b", i), out_b, vecs[i].eb);
      check($sformatf("vec%0d nobypass a", i), nb_a, vecs[i].ena);
      tick();
    end
    Load = 1'b0;

    // Fill, then bulk clear with a stray Clear and a dropped Load inside it
    for (int i = 0; i < 8; i++) begin
      Load = 1'b1; Wr_Addr = AW'(i); Data_In = N'(17 * (i + 1));
      tick();
    end
    Load = 1'b0; Clear = 1'b1; Rd_Addr_A = 3'd0; Rd_Addr_B = 3'd7;
    tick();
    for (int k = 1; k <= 8; k++) begin
      Clear = (k == 3);
      if (k == 4) begin
        Load = 1'b1; Wr_Addr = 3'd6; Data_In = 16'hFFFF; Rd_Addr_B = 3'd6;
      end else begin
        Load = 1'b0; Rd_Addr_B = 3'd7;
      end
      #1;
      check_bit($sformatf("clr busy k%0d", k), busy, 1'b1);
      check_bit($sformatf("clr done k%0d", k), done, 1'b0);
      check($sformatf("clr r0 k%0d", k), out_a, (k == 1) ? 16'h0011 : 16'h0000);
      check($sformatf("clr b k%0d", k), out_b, (k == 4) ? 16'h0077 : 16'h0088);
      tick();
    end
    Clear = 1'b0; Load = 1'b0; Rd_Addr_B = 3'd7;
    #1;
    check_bit("clr end busy", busy, 1'b0);
    check_bit("clr end done", done, 1'b1);
    check("clr end r7", out_b, 16'h0000);
    tick();
    check_bit("clr done one cycle", done, 1'b0);
    check_bit("clr not restarted", busy, 1'b0);
    Rd_Addr_B = 3'd6;
    #1;
    check("r6 after busy write", out_b, 16'h0000);

    // Load and Clear together, then Clear coinciding with Clear_Done
    Load = 1'b1; Wr_Addr = 3'd4; Data_In = 16'hA5A5; Clear = 1'b1; Rd_Addr_A = 3'd4;
    #1;
    check("load+clear forward", out_a, 16'hA5A5);
    tick();
    Load = 1'b0; Clear = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      Clear = (k == 9);
      #1;
      check($sformatf("lc r4 k%0d", k), out_a, (k <= 5) ? 16'hA5A5 : 16'h0000);
      check_bit($sformatf("lc busy k%0d", k), busy, k <= 8);
      check_bit($sformatf("lc done k%0d", k), done, k == 9);
      tick();
    end
    Clear = 1'b0;
    for (int k = 10; k <= 18; k++) begin
      #1;
      check_bit($sformatf("back2back busy k%0d", k), busy, k <= 17);
      check_bit($sformatf("back2back done k%0d", k), done, k == 18);
      tick();
    end

    // Asynchronous reset in the middle of a clear
    Load = 1'b1; Wr_Addr = 3'd5; Data_In = 16'h5050;
    tick();
    Load = 1'b0; Clear = 1'b1; Rd_Addr_A = 3'd5;
    tick();
    Clear = 1'b0;
    tick(); tick(); tick();
    #2;
    check("pre-abort r5", out_a, 16'h5050);
    check_bit("pre-abort busy", busy, 1'b1);
    Reset_N = 1'b0;
    #1;
    check("abort r5", out_a, 16'h0000);
    check_bit("abort busy", busy, 1'b0);
    check_bit("abort done", done, 1'b0);
    #2 Reset_N = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("done pulses after abort", N'(pulses), 16'h0000);
    Load = 1'b1; Wr_Addr = 3'd1; Data_In = 16'h0101; Rd_Addr_A = 3'd1;
    tick();
    Load = 1'b0;
    #1;
    check("write r1 after reset", out_a, 16'h0101);

    // Six-entry bank: out-of-range write/read and a six-cycle clear
    l6 = 1'b1; wa6 = 3'd6; d6 = 16'hABCD; ra6 = 3'd6; rb6 = 3'd0;
    #1;
    check("d6 no forward oob", a6, 16'h0000);
    tick();
    l6 = 1'b0;
    #1;
    check("d6 oob read", a6, 16'h0000);
    check("d6 oob write no alias r0", b6, 16'h0000);
    l6 = 1'b1; wa6 = 3'd5; d6 = 16'h5A5A; rb6 = 3'd5; ra6 = 3'd7;
    #1;
    check("d6 forward r5", b6, 16'h5A5A);
    tick();
    l6 = 1'b0;
    #1;
    check("d6 r5 stored", b6, 16'h5A5A);
    check("d6 oob r7", a6, 16'h0000);
    clr6 = 1'b1;
    tick();
    clr6 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check_bit($sformatf("d6 busy k%0d", k), busy6, k <= 6);
      check_bit($sformatf("d6 done k%0d", k), done6, k == 7);
      tick();
    end
    #1;
    check("d6 r5 cleared", b6, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (2..256).
REQ-003 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable (1 = on, 0 = off).
REQ-004 SHALL define AW = max(1, ceil(log2(DEPTH))) as the address width.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset_N, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port Load, input, 1, write request for the current cycle.
REQ-008 SHALL have port Wr_Addr, input, AW, write register index.
REQ-009 SHALL have port Data_In, input, N, write data.
REQ-010 SHALL have port Rd_Addr_A, input, AW, read index for port A.
REQ-011 SHALL have port Rd_Addr_B, input, AW, read index for port B.
REQ-012 SHALL have port Data_Out_A, output, N, port A read data.
REQ-013 SHALL have port Data_Out_B, output, N, port B read data.
REQ-014 SHALL have port Clear, input, 1, single-cycle request to start the bulk-clear sequence.
REQ-015 SHALL have port Busy, output, 1, high while the clear sequence runs.
REQ-016 SHALL have port Clear_Done, output, 1, one-cycle pulse when a clear sequence completes.

Function
REQ-017 SHALL accept a write (Load=1, Busy=0, Wr_Addr<DEPTH) at the rising edge, so the entry holds Data_In from the next cycle.
REQ-018 SHALL ignore writes with Wr_Addr>=DEPTH; no entry changes.
REQ-019 SHALL drop Load silently while Busy=1; no queuing.
REQ-020 SHALL make reads combinational (zero latency) on both ports; Rd_Addr>=DEPTH returns all zeros.
REQ-021 SHALL, with BYPASS=1, drive Data_In on a port whose read index equals Wr_Addr while that write is being accepted; with BYPASS=0, that port shows the pre-write value.
REQ-022 SHALL NOT forward while Busy=1, because no write is accepted then.
REQ-023 SHALL implement FSM states IDLE and CLEARING, plus an AW-bit clear counter.
REQ-024 SHALL, in IDLE with Clear=1 at the edge, go to CLEARING with the counter at 0.
REQ-025 SHALL, in CLEARING, zero entry[counter] at each edge and increment the counter.
REQ-026 SHALL, at the edge where counter=DEPTH-1, zero that entry and return to IDLE; the sequence takes exactly DEPTH cycles.
REQ-027 SHALL hold Busy=1 for exactly the DEPTH cycles spent in CLEARING.
REQ-028 SHALL assert Clear_Done for one cycle, in the first cycle after returning to IDLE.
REQ-029 SHALL ignore Clear while in CLEARING; the sequence is not restarted.
REQ-030 SHALL, when Load and Clear are both high in IDLE, perform the write at that edge and then start clearing, so the written entry is eventually zeroed.
REQ-031 SHALL, on reads during CLEARING, return current contents: already-cleared entries read 0 and the rest keep their old values.
REQ-032 SHALL let Clear_Done and a new Clear coincide; the new sequence starts at that edge.

Reset
REQ-033 SHALL, while Reset_N=0 and independent of Clk, force all entries to 0, FSM to IDLE, counter to 0, Busy=0, Clear_Done=0.
REQ-034 SHALL abort an in-progress clear when reset is asserted mid-clear, with no Clear_Done pulse afterwards.
REQ-035 SHALL have outputs Data_Out_A/B read 0 after reset.

Verification (N=16, DEPTH=8, BYPASS=1 unless stated)
REQ-036 SHALL cover: write 0x1234 to r3, then read A=r3, B=r5 -> A=0x1234 from next cycle, B=0x0000.
REQ-037 SHALL cover: Load=1, Wr_Addr=2, Data_In=0xBEEF, Rd_Addr_A=2 in the same cycle -> Data_Out_A=0xBEEF that cycle; with BYPASS=0 -> old value 0x0000.
REQ-038 SHALL cover: fill r0..r7 with 0x0011..0x0088, pulse Clear -> Busy high exactly 8 cycles, r0 reads 0 after 1 cycle while r7 keeps 0x0088 until the 8th edge, then Clear_Done pulses once.
REQ-039 SHALL cover: during Busy, Load=1 Wr_Addr=6 Data_In=0xFFFF -> r6 ends at 0x0000 and no forwarding occurs.
REQ-040 SHALL cover: Load to r4 with 0xA5A5 and Clear in the same IDLE cycle -> r4 reads 0xA5A5 until its clear step, then 0x0000.
REQ-041 SHALL cover: drop Reset_N to 0 asynchronously at clear step 3 -> immediate all-zero, Busy=0, no Clear_Done; then a normal write to r1 succeeds.
